// File: rtl/i2c_cfg_sequencer.sv
// Register-table bring-up sequencer: walks a ROM of {addr, data} entries and drives a
// single-register I2C engine per entry, with optional readback verify and bounded retries.
module i2c_cfg_sequencer #(
   parameter int unsigned LUT_SIZE  = 64,
   parameter int unsigned IDX_W     = 8,
   parameter bit          VERIFY    = 1'b1,
   parameter int unsigned MAX_RETRY = 3,
   parameter logic [7:0]  DEVICE_ID = 8'h78,
   parameter bit          ADDR_MODE = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o,
   output logic [IDX_W-1:0] err_cnt_o,
   output logic [IDX_W-1:0] err_index_o,
   output logic [IDX_W-1:0] lut_index_o,
   input  logic [23:0]      lut_data_i,
   output logic             wrreg_req_o,
   output logic             rdreg_req_o,
   output logic [15:0]      addr_o,
   output logic             addr_mode_o,
   output logic [7:0]       wrdata_o,
   output logic [7:0]       device_id_o,
   input  logic [7:0]       rddata_i,
   input  logic             rw_done_i,
   input  logic             ack_i
);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LUT_SIZE - 1);
   localparam logic [IDX_W-1:0] CNT_MAX   = {IDX_W{1'b1}};
   localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_LATCH   = 4'd2,
      S_WR_REQ  = 4'd3,
      S_WR_WAIT = 4'd4,
      S_RD_REQ  = 4'd5,
      S_RD_WAIT = 4'd6,
      S_FAIL    = 4'd7,
      S_NEXT    = 4'd8,
      S_FIN     = 4'd9
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      addr_q, addr_d;
   logic [7:0]       wrdata_q, wrdata_d;
   logic [3:0]       retry_q, retry_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] err_cnt_q, err_cnt_d;
   logic [IDX_W-1:0] err_idx_q, err_idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wr_q, wr_d;
   logic             rd_q, rd_d;
   logic             rd_ok_s;

   assign rd_ok_s = !ack_i && (rddata_i == wrdata_q);

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; RW_Done outside the two wait states falls through unused
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    state_d = start_i ? S_FETCH : S_IDLE;
         S_FETCH:   state_d = S_LATCH;
         S_LATCH:   state_d = S_WR_REQ;
         S_WR_REQ:  state_d = S_WR_WAIT;
         S_WR_WAIT: begin
            if (!rw_done_i) begin
               state_d = S_WR_WAIT;
            end else if (ack_i) begin
               state_d = S_FAIL;
            end else begin
               state_d = VERIFY ? S_RD_REQ : S_NEXT;
            end
         end
         S_RD_REQ:  state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (!rw_done_i) begin
               state_d = S_RD_WAIT;
            end else begin
               state_d = rd_ok_s ? S_NEXT : S_FAIL;
            end
         end
         S_FAIL:    state_d = (retry_q < RETRY_LIM) ? S_WR_REQ : S_NEXT;
         S_NEXT:    state_d = (idx_q == LAST_IDX) ? S_FIN : S_FETCH;
         S_FIN:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the next state so they register in step with the FSM
   always_comb begin
      busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
      done_d = (state_d == S_FIN);
      wr_d   = (state_d == S_WR_REQ);
      rd_d   = (state_d == S_RD_REQ);
   end

   // Datapath next-state: index walk, entry latch, retry and failure logging
   always_comb begin
      idx_d     = idx_q;
      addr_d    = addr_q;
      wrdata_d  = wrdata_q;
      retry_d   = retry_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      err_idx_d = err_idx_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               idx_d     = '0;
               retry_d   = 4'd0;
               err_d     = 1'b0;
               err_cnt_d = '0;
               err_idx_d = '0;
            end else begin
               idx_d = idx_q;
            end
         end
         S_LATCH: begin
            addr_d   = lut_data_i[23:8];
            wrdata_d = lut_data_i[7:0];
         end
         S_FAIL: begin
            if (retry_q < RETRY_LIM) begin
               retry_d = retry_q + 4'd1;
            end else begin
               err_d     = 1'b1;
               err_idx_d = err_q ? err_idx_q : idx_q;
               err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + IDX_W'(1);
            end
         end
         S_NEXT: begin
            retry_d = 4'd0;
            if (idx_q != LAST_IDX) begin
               idx_d = idx_q + IDX_W'(1);
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            idx_d = idx_q;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q     <= '0;
         addr_q    <= 16'h0000;
         wrdata_q  <= 8'h00;
         retry_q   <= 4'd0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         err_idx_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         wrdata_q  <= wrdata_d;
         retry_q   <= retry_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         err_idx_q <= err_idx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = err_q;
   assign err_cnt_o   = err_cnt_q;
   assign err_index_o = err_idx_q;
   assign lut_index_o = idx_q;
   assign wrreg_req_o = wr_q;
   assign rdreg_req_o = rd_q;
   assign addr_o      = addr_q;
   assign wrdata_o    = wrdata_q;
   assign addr_mode_o = ADDR_MODE;
   assign device_id_o = DEVICE_ID;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: two 4-entry instances (write-only and verify), a randomized
// I2C engine responder, and a transaction-list reference model built from the table rules.
module tb_i2c_cfg_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start0, start1, sel;
   logic [23:0] lut_data;
   logic [7:0]  rddata;
   logic        rw_done, ack;

   logic       busy0, done0, error0, wr0, rd0, amode0;
   logic [7:0] ecnt0, eidx0, idx0, wrdata0, devid0;
   logic [15:0] addr0;
   logic       busy1, done1, error1, wr1, rd1, amode1;
   logic [7:0] ecnt1, eidx1, idx1, wrdata1, devid1;
   logic [15:0] addr1;

   i2c_cfg_sequencer #(.LUT_SIZE(4), .IDX_W(8), .VERIFY(1'b0), .MAX_RETRY(3)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .start_i(start0), .busy_o(busy0), .done_o(done0),
      .error_o(error0), .err_cnt_o(ecnt0), .err_index_o(eidx0), .lut_index_o(idx0),
      .lut_data_i(lut_data), .wrreg_req_o(wr0), .rdreg_req_o(rd0), .addr_o(addr0),
      .addr_mode_o(amode0), .wrdata_o(wrdata0), .device_id_o(devid0), .rddata_i(rddata),
      .rw_done_i(rw_done), .ack_i(ack));

   i2c_cfg_sequencer #(.LUT_SIZE(4), .IDX_W(8), .VERIFY(1'b1), .MAX_RETRY(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .busy_o(busy1), .done_o(done1),
      .error_o(error1), .err_cnt_o(ecnt1), .err_index_o(eidx1), .lut_index_o(idx1),
      .lut_data_i(lut_data), .wrreg_req_o(wr1), .rdreg_req_o(rd1), .addr_o(addr1),
      .addr_mode_o(amode1), .wrdata_o(wrdata1), .device_id_o(devid1), .rddata_i(rddata),
      .rw_done_i(rw_done), .ack_i(ack));

   // Only the selected instance is started; the other stays idle and ignores RW_Done.
   wire        m_busy  = sel ? busy1 : busy0;
   wire        m_done  = sel ? done1 : done0;
   wire        m_err   = sel ? error1 : error0;
   wire [7:0]  m_ecnt  = sel ? ecnt1 : ecnt0;
   wire [7:0]  m_eidx  = sel ? eidx1 : eidx0;
   wire [7:0]  m_idx   = sel ? idx1 : idx0;
   wire        m_wr    = sel ? wr1 : wr0;
   wire        m_rd    = sel ? rd1 : rd0;
   wire [15:0] m_addr  = sel ? addr1 : addr0;
   wire [7:0]  m_wdat  = sel ? wrdata1 : wrdata0;
   wire        m_amode = sel ? amode1 : amode0;
   wire [7:0]  m_devid = sel ? devid1 : devid0;

   logic [23:0] tbl [4];
   always @(posedge clk) lut_data <= tbl[m_idx[1:0]];

   typedef struct packed { logic rd; logic [15:0] a; logic [7:0] d; } txn_t;
   typedef struct packed { logic nack; logic [7:0] rdd; } rsp_t;

   txn_t exp_q[$];
   txn_t act_q[$];
   rsp_t rsp_q[$];
   logic       wr_nack [4][16];
   logic [7:0] rd_mask [4][16];
   logic exp_err;
   int   exp_cnt, exp_idx;
   int   checks = 0, errors = 0;
   int   done_cnt = 0, overlap_cnt = 0;

   task automatic clear_faults();
      for (int e = 0; e < 4; e++)
         for (int a = 0; a < 16; a++) begin
            wr_nack[e][a] = 1'b0;
            rd_mask[e][a] = 8'h00;
         end
   endtask

   task automatic new_table();
      for (int e = 0; e < 4; e++) tbl[e] = {4'(e), 12'($urandom), 8'($urandom)};
   endtask

   // Reference: the transactions each entry should see and the engine replies for them.
   task automatic build_model(input bit verify, input int maxr);
      bit ok;
      exp_q.delete(); rsp_q.delete();
      exp_err = 1'b0; exp_cnt = 0; exp_idx = 0;
      for (int e = 0; e < 4; e++) begin
         ok = 1'b0;
         for (int a = 0; a <= maxr && !ok; a++) begin
            exp_q.push_back('{1'b0, tbl[e][23:8], tbl[e][7:0]});
            rsp_q.push_back('{wr_nack[e][a], 8'h00});
            if (!wr_nack[e][a]) begin
               if (verify) begin
                  exp_q.push_back('{1'b1, tbl[e][23:8], tbl[e][7:0]});
                  rsp_q.push_back('{1'b0, tbl[e][7:0] ^ rd_mask[e][a]});
                  ok = (rd_mask[e][a] == 8'h00);
               end else begin
                  ok = 1'b1;
               end
            end
         end
         if (!ok) begin
            if (!exp_err) exp_idx = e;
            exp_err = 1'b1;
            exp_cnt++;
         end
      end
   endtask

   // Engine model: replies to each request after a random 1..4 cycle delay.
   initial begin
      rsp_t r;
      int   lat;
      rw_done = 1'b0; ack = 1'b0; rddata = 8'h00;
      forever begin
         if (m_wr === 1'b1 || m_rd === 1'b1) begin
            if (rsp_q.size() > 0) r = rsp_q.pop_front();
            else r = '{1'b0, 8'h00};
            lat = $urandom_range(4, 1);
            repeat (lat) @(posedge clk);
            #1;
            rw_done = 1'b1; ack = r.nack; rddata = r.rdd;
            @(posedge clk); #1;
            rw_done = 1'b0; ack = 1'($urandom); rddata = 8'($urandom);
         end else begin
            @(posedge clk); #1;
         end
      end
   end

   // Transaction monitor
   initial forever begin
      @(posedge clk); #1;
      if (m_wr === 1'b1 && m_rd === 1'b1) overlap_cnt++;
      if (m_wr === 1'b1) act_q.push_back('{1'b0, m_addr, m_wdat});
      if (m_rd === 1'b1) act_q.push_back('{1'b1, m_addr, m_wdat});
      if (m_done === 1'b1) done_cnt++;
   end

   task automatic do_start(input bit s);
      int lat;
      sel = s;
      if (s) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #2;
      start0 = 1'b0; start1 = 1'b0;
      checks++;
      if (m_busy !== 1'b1 || m_idx !== 8'h00) begin
         errors++;
         $display("FAIL start_accept: busy=%b idx=%0d, required busy=1 idx=0", m_busy, m_idx);
      end
      lat = 1;
      while (m_wr !== 1'b1 && lat < 20) begin
         @(posedge clk); #2;
         lat++;
      end
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL start_latency: %0d cycles, required 3", lat);
      end
   endtask

   task automatic wait_done(output bit ok);
      int n = 0;
      while (m_done !== 1'b1 && n < 3000) begin
         @(posedge clk); #2;
         n++;
      end
      ok = (m_done === 1'b1);
   endtask

   task automatic run_seq(input bit s, input bit verify, input int maxr, input string name);
      bit ok;
      int n;
      act_q.delete(); done_cnt = 0; overlap_cnt = 0;
      build_model(verify, maxr);
      do_start(s);
      wait_done(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_done_timeout: done not seen, required within 3000 cycles", name);
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (done_cnt !== 1 || m_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_done: pulses=%0d busy=%b, required 1 pulse busy=0", name, done_cnt, m_busy);
      end
      checks++;
      if (m_err !== exp_err || m_ecnt !== 8'(exp_cnt) || m_eidx !== 8'(exp_idx)) begin
         errors++;
         $display("FAIL %s_errstat: error=%b cnt=%0d idx=%0d, required error=%b cnt=%0d idx=%0d",
                  name, m_err, m_ecnt, m_eidx, exp_err, exp_cnt, exp_idx);
      end
      checks++;
      if (act_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL %s_txn_count: %0d, required %0d", name, act_q.size(), exp_q.size());
      end
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (act_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s_txn[%0d]: rd=%b a=%h d=%h, required rd=%b a=%h d=%h", name, i,
                     act_q[i].rd, act_q[i].a, act_q[i].d, exp_q[i].rd, exp_q[i].a, exp_q[i].d);
         end
      end
      checks++;
      if (overlap_cnt !== 0) begin
         errors++;
         $display("FAIL %s_overlap: %0d cycles with both requests, required 0", name, overlap_cnt);
      end
   endtask

   function automatic int writes_to(input int e);
      int c = 0;
      foreach (act_q[i]) if (!act_q[i].rd && act_q[i].a[15:12] == 4'(e)) c++;
      return c;
   endfunction

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s); #1;
         checks++;
         if ({m_busy, m_done, m_err, m_ecnt, m_eidx, m_idx, m_wr, m_rd, m_addr, m_wdat} !== 53'd0 ||
             {m_amode, m_devid} !== 9'h178) begin
            errors++;
            $display("FAIL reset_values[%0d]: busy=%b done=%b err=%b idx=%0d addr=%h amode=%b devid=%h, required zeros amode=1 devid=78",
                     s, m_busy, m_done, m_err, m_idx, m_addr, m_amode, m_devid);
         end
      end
   endtask

   task automatic test_write_only();
      clear_faults(); new_table();
      run_seq(1'b0, 1'b0, 3, "write_only");
   endtask

   task automatic test_retry_recover();
      clear_faults(); new_table();
      wr_nack[2][0] = 1'b1; wr_nack[2][1] = 1'b1;
      run_seq(1'b0, 1'b0, 3, "retry_recover");
      checks++;
      if (writes_to(2) !== 3) begin
         errors++;
         $display("FAIL retry_recover_writes: entry 2 written %0d times, required 3", writes_to(2));
      end
   endtask

   task automatic test_verify();
      clear_faults(); new_table();
      run_seq(1'b1, 1'b1, 2, "verify");
   endtask

   task automatic test_nack_exhaust();
      clear_faults(); new_table();
      for (int a = 0; a < 16; a++) wr_nack[1][a] = 1'b1;
      run_seq(1'b1, 1'b1, 2, "nack_exhaust");
      checks++;
      if (writes_to(1) !== 3 || m_eidx !== 8'd1 || m_ecnt !== 8'd1 || m_err !== 1'b1) begin
         errors++;
         $display("FAIL nack_exhaust_entry1: writes=%0d idx=%0d cnt=%0d err=%b, required 3 1 1 1",
                  writes_to(1), m_eidx, m_ecnt, m_err);
      end
   endtask

   task automatic test_mismatch();
      clear_faults(); new_table();
      for (int a = 0; a < 16; a++) rd_mask[3][a] = 8'h01;
      run_seq(1'b1, 1'b1, 2, "mismatch");
      checks++;
      if (writes_to(3) !== 3 || m_eidx !== 8'd3) begin
         errors++;
         $display("FAIL mismatch_entry3: writes=%0d idx=%0d, required 3 and 3", writes_to(3), m_eidx);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         new_table();
         for (int e = 0; e < 4; e++)
            for (int a = 0; a < 16; a++) begin
               wr_nack[e][a] = ($urandom_range(2, 0) == 0);
               rd_mask[e][a] = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            end
         run_seq(1'(it), 1'(it), (it % 2 == 1) ? 2 : 3, "random");
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_faults(); new_table();
      act_q.delete(); done_cnt = 0;
      build_model(1'b0, 3);
      do_start(1'b0);
      wait_done(ok);
      start0 = 1'b1;
      @(posedge clk); #2;
      checks++;
      if (!ok || m_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start_with_done: done_seen=%b busy=%b, required done seen and busy=0", ok, m_busy);
      end
      checks++;
      if (act_q.size() !== 4) begin
         errors++;
         $display("FAIL b2b_first_run: %0d writes, required 4", act_q.size());
      end
      act_q.delete();
      build_model(1'b0, 3);
      @(posedge clk); #2;
      start0 = 1'b0;
      checks++;
      if (m_busy !== 1'b1 || m_idx !== 8'h00) begin
         errors++;
         $display("FAIL b2b_start_after_done: busy=%b idx=%0d, required busy=1 idx=0", m_busy, m_idx);
      end
      wait_done(ok);
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (!ok || done_cnt !== 2 || act_q.size() !== 4 || m_err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_run: done_seen=%b pulses=%0d writes=%0d err=%b, required 1 2 4 0",
                  ok, done_cnt, act_q.size(), m_err);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int d0;
      clear_faults(); new_table();
      act_q.delete(); done_cnt = 0;
      build_model(1'b1, 2);
      do_start(1'b1);
      while (act_q.size() < 3 && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      checks++;
      if (act_q.size() < 3) begin
         errors++;
         $display("FAIL reset_mid_reach: %0d transactions, required 3", act_q.size());
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      d0 = done_cnt;
      checks++;
      if ({m_busy, m_done, m_err, m_ecnt, m_eidx, m_idx, m_wr, m_rd, m_addr, m_wdat} !== 53'd0 ||
          {m_amode, m_devid} !== 9'h178) begin
         errors++;
         $display("FAIL reset_mid_values: busy=%b idx=%0d addr=%h wrdata=%h, required all zero",
                  m_busy, m_idx, m_addr, m_wdat);
      end
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      checks++;
      if (done_cnt !== d0 || m_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_done: pulses=%0d busy=%b, required %0d and 0", done_cnt, m_busy, d0);
      end
      clear_faults();
      run_seq(1'b1, 1'b1, 2, "restart");
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
      clear_faults(); new_table();
      repeat (3) @(posedge clk);
      #2;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #2;
      test_write_only();
      test_retry_recover();
      test_verify();
      test_nack_exhaust();
      test_mismatch();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
